sample_sequencer: RTL and testbench

Upstream feeder for the network control FSM. Accepts training/inference samples from a ready/valid word stream, writes input activations into layer 0 of the y RAM and targets into the target buffer, then releases the control FSM by dropping `done`. On each end-of-pass `valid` pulse from the control FSM it loads the next sample, sequencing samples and epochs until the run completes.

---
 rtl/sample_sequencer_pkg.sv | 14 +
 rtl/sample_sequencer_frame_counter.sv | 83 ++++++++
 rtl/sample_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_sample_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_sequencer_pkg.sv
// Shared definitions for the sample sequencer and the network datapath.
// Holds the datapath word type, default network geometry, the learning
// rate, and the default run length (samples per epoch, epochs per run).
package sample_sequencer_pkg;

  // Datapath word; the sequencer's DATA_W parameter must match its width.
  typedef logic [15:0] data;

  localparam int  MAX_NEURONS   = 4;
  localparam data LEARNING_RATE = 16'h0010;  // Q8.8, 1/16
  localparam int  NUM_SAMPLES   = 8;
  localparam int  NUM_EPOCHS    = 4;

endpackage

// File: rtl/sample_sequencer_frame_counter.sv
// frame_counter: nested word / sample / epoch counter.
//   clk, rst_n      : clock, async active-low reset
//   clr             : synchronous clear of all three counters
//   word_inc        : one word of the current sample was accepted
//   sample_adv      : advance to the next sample (epoch rolls on wrap)
//   word_idx        : word position within the sample, 0..2*MAX_NEURONS-1
//   word_last_x     : word_idx is the last input word
//   word_last       : word_idx is the last word of the sample
//   sample_idx      : sample position within the epoch
//   epoch_idx       : epoch position within the run
//   sample_tc/epoch_tc : terminal-count flags
// Sample and epoch counters saturate at their terminal counts.
module frame_counter
  import sample_sequencer_pkg::*;
#(
  parameter int MAX_NEURONS = sample_sequencer_pkg::MAX_NEURONS,
  parameter int NUM_SAMPLES = sample_sequencer_pkg::NUM_SAMPLES,
  parameter int NUM_EPOCHS  = sample_sequencer_pkg::NUM_EPOCHS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic word_inc,
  input  logic sample_adv,
  output int   word_idx,
  output logic word_last_x,
  output logic word_last,
  output int   sample_idx,
  output int   epoch_idx,
  output logic sample_tc,
  output logic epoch_tc
);

  int word_q, word_d;
  int sample_q, sample_d;
  int epoch_q, epoch_d;

  assign word_last_x = (word_q == MAX_NEURONS - 1);
  assign word_last   = (word_q == 2 * MAX_NEURONS - 1);
  assign sample_tc   = (sample_q == NUM_SAMPLES - 1);
  assign epoch_tc    = (epoch_q == NUM_EPOCHS - 1);

  always_comb begin
    word_d   = word_q;
    sample_d = sample_q;
    epoch_d  = epoch_q;
    if (clr) begin
      word_d   = 0;
      sample_d = 0;
      epoch_d  = 0;
    end else begin
      if (word_inc) begin
        word_d = word_last ? 0 : word_q + 1;
      end
      if (sample_adv) begin
        if (!sample_tc) begin
          sample_d = sample_q + 1;
        end else if (!epoch_tc) begin
          sample_d = 0;
          epoch_d  = epoch_q + 1;
        end
        // both at terminal count: hold, never wrap past a finished run
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= 0;
      sample_q <= 0;
      epoch_q  <= 0;
    end else begin
      word_q   <= word_d;
      sample_q <= sample_d;
      epoch_q  <= epoch_d;
    end
  end

  assign word_idx   = word_q;
  assign sample_idx = sample_q;
  assign epoch_idx  = epoch_q;

endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: feeds samples from a ready/valid word stream into the
// layer-0 y RAM (inputs) and the target buffer (targets), then releases the
// control FSM by dropping done. Each end-of-pass valid loads the next sample
// until all samples (and, in training, all epochs) are done.
//   CLK, RST_N                 : clock, async active-low reset
//   start, train_mode          : begin run; mode latched at accepted start
//   s_valid/s_ready/s_data/s_last : sample word stream
//   valid                      : end-of-pass pulse from the control FSM
//   done                       : holds the control FSM idle while high
//   train                      : latched train_mode
//   y0_we/y0_index/y0_data     : layer-0 y RAM write port
//   t_we/t_index/t_data        : target buffer write port
//   sample_count, epoch_count  : current position in the run
//   err                        : sticky framing error
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | after reset; waiting for start, control FSM held
// ST_LOAD_X | accepting the MAX_NEURONS input words of a sample
// ST_LOAD_T | accepting the MAX_NEURONS target words of a sample
// ST_ARM    | one-cycle gap so the last RAM write lands before release
// ST_RUN    | control FSM released; waiting for end-of-pass valid
// ST_FINISH | run complete or framing error; waiting for a new start
module sample_sequencer
  import sample_sequencer_pkg::*;
#(
  parameter int MAX_NEURONS = sample_sequencer_pkg::MAX_NEURONS,
  parameter int DATA_W      = 16,
  parameter int NUM_SAMPLES = sample_sequencer_pkg::NUM_SAMPLES,
  parameter int NUM_EPOCHS  = sample_sequencer_pkg::NUM_EPOCHS
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              train_mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              valid,
  output logic              done,
  output logic              train,
  output logic              y0_we,
  output int                y0_index,
  output data               y0_data,
  output logic              t_we,
  output int                t_index,
  output data               t_data,
  output int                sample_count,
  output int                epoch_count,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_X,
    ST_LOAD_T,
    ST_ARM,
    ST_RUN,
    ST_FINISH
  } state_t;

  state_t state_q, state_d;
  logic   done_q, done_d;
  logic   train_q, train_d;
  logic   err_q, err_d;
  logic   y0_we_q, y0_we_d;
  int     y0_index_q, y0_index_d;
  data    y0_data_q, y0_data_d;
  logic   t_we_q, t_we_d;
  int     t_index_q, t_index_d;
  data    t_data_q, t_data_d;

  logic cnt_clr, word_inc, sample_adv;
  int   word_idx;
  logic word_last_x, word_last, sample_tc, epoch_tc;
  logic hs, frame_bad, run_finished;

  frame_counter #(
    .MAX_NEURONS(MAX_NEURONS),
    .NUM_SAMPLES(NUM_SAMPLES),
    .NUM_EPOCHS (NUM_EPOCHS)
  ) u_frame_counter (
    .clk        (CLK),
    .rst_n      (RST_N),
    .clr        (cnt_clr),
    .word_inc   (word_inc),
    .sample_adv (sample_adv),
    .word_idx   (word_idx),
    .word_last_x(word_last_x),
    .word_last  (word_last),
    .sample_idx (sample_count),
    .epoch_idx  (epoch_count),
    .sample_tc  (sample_tc),
    .epoch_tc   (epoch_tc)
  );

  assign s_ready      = (state_q == ST_LOAD_X) || (state_q == ST_LOAD_T);
  assign hs           = s_valid && s_ready;
  // s_last must be high exactly on the final word of the sample
  assign frame_bad    = (s_last != word_last);
  assign run_finished = sample_tc && (!train_q || epoch_tc);

  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    train_d    = train_q;
    err_d      = err_q;
    y0_we_d    = 1'b0;
    y0_index_d = y0_index_q;
    y0_data_d  = y0_data_q;
    t_we_d     = 1'b0;
    t_index_d  = t_index_q;
    t_data_d   = t_data_q;
    cnt_clr    = 1'b0;
    word_inc   = 1'b0;
    sample_adv = 1'b0;

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        done_d = 1'b1;
        if (start) begin
          train_d = train_mode;
          err_d   = 1'b0;
          cnt_clr = 1'b1;
          state_d = ST_LOAD_X;
        end
      end
      ST_LOAD_X, ST_LOAD_T: begin
        if (hs) begin
          if (frame_bad) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            word_inc = 1'b1;
            if (state_q == ST_LOAD_X) begin
              y0_we_d    = 1'b1;
              y0_index_d = word_idx;
              y0_data_d  = s_data;
              if (word_last_x) state_d = ST_LOAD_T;
            end else begin
              // targets are always consumed, only written when training
              if (train_q) begin
                t_we_d    = 1'b1;
                t_index_d = word_idx - MAX_NEURONS;
                t_data_d  = s_data;
              end
              if (word_last) state_d = ST_ARM;
            end
          end
        end
      end
      ST_ARM: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        done_d = 1'b0;
        if (valid) begin
          done_d = 1'b1;
          if (run_finished) begin
            state_d = ST_FINISH;
          end else begin
            sample_adv = 1'b1;
            state_d    = ST_LOAD_X;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b1;
      train_q    <= 1'b0;
      err_q      <= 1'b0;
      y0_we_q    <= 1'b0;
      y0_index_q <= 0;
      y0_data_q  <= '0;
      t_we_q     <= 1'b0;
      t_index_q  <= 0;
      t_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      train_q    <= train_d;
      err_q      <= err_d;
      y0_we_q    <= y0_we_d;
      y0_index_q <= y0_index_d;
      y0_data_q  <= y0_data_d;
      t_we_q     <= t_we_d;
      t_index_q  <= t_index_d;
      t_data_q   <= t_data_d;
    end
  end

  assign done     = done_q;
  assign train    = train_q;
  assign err      = err_q;
  assign y0_we    = y0_we_q;
  assign y0_index = y0_index_q;
  assign y0_data  = y0_data_q;
  assign t_we     = t_we_q;
  assign t_index  = t_index_q;
  assign t_data   = t_data_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer (MAX_NEURONS=4, NUM_SAMPLES=2,
// NUM_EPOCHS=2). Write strobes are logged into queues at the falling edge;
// the main sequence compares them against hand-computed expectations.
module tb_sample_sequencer;

  localparam int MN = 4;
  localparam int NS = 2;
  localparam int NE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        train_mode = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        valid = 1'b0;
  logic        s_ready, done, train, y0_we, t_we, err;
  int          y0_index, t_index, sample_count, epoch_count;
  logic [15:0] y0_data, t_data;

  int checks = 0;
  int errors = 0;

  int yq_idx[$];
  int yq_dat[$];
  int tq_idx[$];
  int tq_dat[$];

  always #5 clk = ~clk;

  sample_sequencer #(
    .MAX_NEURONS(MN),
    .DATA_W     (16),
    .NUM_SAMPLES(NS),
    .NUM_EPOCHS (NE)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .start       (start),
    .train_mode  (train_mode),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .valid       (valid),
    .done        (done),
    .train       (train),
    .y0_we       (y0_we),
    .y0_index    (y0_index),
    .y0_data     (y0_data),
    .t_we        (t_we),
    .t_index     (t_index),
    .t_data      (t_data),
    .sample_count(sample_count),
    .epoch_count (epoch_count),
    .err         (err)
  );

  always @(negedge clk) begin
    if (y0_we) begin
      yq_idx.push_back(y0_index);
      yq_dat.push_back(int'(y0_data));
    end
    if (t_we) begin
      tq_idx.push_back(t_index);
      tq_dat.push_back(int'(t_data));
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word; returns just after the edge that accepted it.
  task automatic send_word(input int d, input logic l, input bit gap);
    int n = 0;
    if (gap) begin
      s_valid = 1'b0;
      tick();
    end
    s_valid = 1'b1;
    s_data  = 16'(d);
    s_last  = l;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (!s_ready) chk("s_ready_timeout", int'(s_ready), 1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_sample(input int base, input bit gap);
    for (int i = 0; i < 2 * MN; i++) send_word(base + i, (i == 2 * MN - 1), gap);
  endtask

  task automatic pulse_start(input logic tm);
    start      = 1'b1;
    train_mode = tm;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_valid();
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (done && n < 50) begin
      tick();
      n++;
    end
    chk(tag, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int yb, tb_base;

    // reset state
    tick();
    tick();
    chk("rst_done", int'(done), 1);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_train", int'(train), 0);
    chk("rst_y0_we", int'(y0_we), 0);
    chk("rst_y0_index", y0_index, 0);
    chk("rst_y0_data", int'(y0_data), 0);
    chk("rst_t_we", int'(t_we), 0);
    chk("rst_t_index", t_index, 0);
    chk("rst_t_data", int'(t_data), 0);
    chk("rst_sample", sample_count, 0);
    chk("rst_epoch", epoch_count, 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    tick();

    // stream data while idle is ignored
    s_valid = 1'b1;
    s_data  = 16'hdead;
    tick();
    tick();
    s_valid = 1'b0;
    chk("idle_no_write", yq_idx.size(), 0);
    chk("idle_s_ready", int'(s_ready), 0);

    // inference, sample 0: inputs 1..4, targets 5..8
    pulse_start(1'b0);
    chk("inf_s_ready", int'(s_ready), 1);
    chk("inf_train", int'(train), 0);
    yb = yq_idx.size();
    tb_base = tq_idx.size();
    send_sample(1, 1'b0);
    chk("inf_done_k", int'(done), 1);
    tick();
    chk("inf_done_k1", int'(done), 1);
    tick();
    chk("inf_done_k2", int'(done), 0);
    chk("inf_y_count", yq_idx.size() - yb, MN);
    for (int i = 0; i < MN; i++) begin
      if (yb + i < yq_idx.size()) begin
        chk($sformatf("inf_y_idx%0d", i), yq_idx[yb + i], i);
        chk($sformatf("inf_y_dat%0d", i), yq_dat[yb + i], i + 1);
      end
    end
    chk("inf_no_t_we", tq_idx.size() - tb_base, 0);

    pulse_valid();
    chk("inf_valid_done", int'(done), 1);
    chk("inf_valid_sample", sample_count, 1);
    chk("inf_loadx_ready", int'(s_ready), 1);

    // valid in LOAD_X is ignored
    pulse_valid();
    chk("ign_valid_sample", sample_count, 1);
    chk("ign_valid_ready", int'(s_ready), 1);
    chk("ign_valid_epoch", epoch_count, 0);

    yb = yq_idx.size();
    send_sample(9, 1'b0);
    chk("inf2_y_count", yq_idx.size() - yb, MN);
    if (yq_idx.size() > yb) chk("inf2_y_first", yq_dat[yb], 9);
    wait_run("inf2_run");
    pulse_valid();
    chk("inf_fin_done", int'(done), 1);
    tick();
    tick();
    chk("inf_fin_done_hold", int'(done), 1);
    chk("inf_fin_ready", int'(s_ready), 0);
    chk("inf_fin_sample", sample_count, 1);
    chk("inf_fin_epoch", epoch_count, 0);
    pulse_valid();
    chk("inf_fin_sat_sample", sample_count, 1);

    // training: 2 samples x 2 epochs
    pulse_start(1'b1);
    chk("trn_train", int'(train), 1);
    chk("trn_sample0", sample_count, 0);
    for (int s = 0; s < NS * NE; s++) begin
      tb_base = tq_idx.size();
      send_sample(100 * (s + 1), 1'b0);
      chk($sformatf("trn%0d_t_we_last", s), int'(t_we), 1);
      chk($sformatf("trn%0d_t_idx_last", s), t_index, MN - 1);
      chk($sformatf("trn%0d_t_dat_last", s), int'(t_data), 100 * (s + 1) + 2 * MN - 1);
      wait_run($sformatf("trn%0d_run", s));
      chk($sformatf("trn%0d_t_count", s), tq_idx.size() - tb_base, MN);
      if (s == 0) begin
        for (int j = 0; j < MN; j++) begin
          if (tb_base + j < tq_idx.size()) begin
            chk($sformatf("trn_t_idx%0d", j), tq_idx[tb_base + j], j);
            chk($sformatf("trn_t_dat%0d", j), tq_dat[tb_base + j], 104 + j);
          end
        end
      end
      pulse_valid();
      if (s == 1) begin
        chk("trn_wrap_epoch", epoch_count, 1);
        chk("trn_wrap_sample", sample_count, 0);
      end
    end
    chk("trn_end_epoch", epoch_count, 1);
    chk("trn_end_sample", sample_count, 1);
    chk("trn_end_done", int'(done), 1);
    tick();
    chk("trn_end_ready", int'(s_ready), 0);

    // back-pressure: s_valid toggles every cycle
    pulse_start(1'b1);
    yb = yq_idx.size();
    tb_base = tq_idx.size();
    send_sample(200, 1'b1);
    wait_run("bp_run");
    chk("bp_y_count", yq_idx.size() - yb, MN);
    chk("bp_t_count", tq_idx.size() - tb_base, MN);
    for (int i = 0; i < MN; i++) begin
      if (yb + i < yq_idx.size()) begin
        chk($sformatf("bp_y_idx%0d", i), yq_idx[yb + i], i);
        chk($sformatf("bp_y_dat%0d", i), yq_dat[yb + i], 200 + i);
      end
      if (tb_base + i < tq_idx.size()) begin
        chk($sformatf("bp_t_idx%0d", i), tq_idx[tb_base + i], i);
        chk($sformatf("bp_t_dat%0d", i), tq_dat[tb_base + i], 204 + i);
      end
    end
    pulse_valid();
    chk("bp_next_sample", sample_count, 1);

    // reset in the middle of LOAD_T
    for (int i = 0; i < MN + 2; i++) send_word(300 + i, 1'b0, 1'b0);
    chk("mid_in_load_t", int'(s_ready), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_done", int'(done), 1);
    chk("mid_rst_ready", int'(s_ready), 0);
    chk("mid_rst_sample", sample_count, 0);
    chk("mid_rst_epoch", epoch_count, 0);
    chk("mid_rst_train", int'(train), 0);
    chk("mid_rst_t_we", int'(t_we), 0);
    chk("mid_rst_t_index", t_index, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_idle_ready", int'(s_ready), 0);
    chk("mid_rst_idle_done", int'(done), 1);

    // framing: s_last on word 2
    pulse_start(1'b0);
    yb = yq_idx.size();
    send_word(400, 1'b0, 1'b0);
    send_word(401, 1'b0, 1'b0);
    send_word(402, 1'b1, 1'b0);
    chk("frm_err", int'(err), 1);
    chk("frm_no_we", int'(y0_we), 0);
    chk("frm_ready", int'(s_ready), 0);
    chk("frm_done", int'(done), 1);
    tick();
    chk("frm_y_count", yq_idx.size() - yb, 2);
    pulse_start(1'b0);
    chk("frm_clear_err", int'(err), 0);
    chk("frm_restart_ready", int'(s_ready), 1);

    // framing: s_last missing on the final word
    yb = yq_idx.size();
    for (int i = 0; i < 2 * MN; i++) send_word(500 + i, 1'b0, 1'b0);
    chk("frm2_err", int'(err), 1);
    chk("frm2_ready", int'(s_ready), 0);
    tick();
    chk("frm2_y_count", yq_idx.size() - yb, MN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
